fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PCF value loaded on reset.
REQ-002 Parameter: NOP_INSTR, 32'h0000_0013, instruction placed in IF/ID on reset or flush (addi x0,x0,0).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 StallF  input  1  hold PCF.
REQ-006 StallD  input  1  hold IF/ID register.
REQ-007 FlushD  input  1  invalidate IF/ID register.
REQ-008 PCSrcE  input  2  next-PC select from Execute: 00 sequential, 01 branch/jal, 10 jalr, 11 reserved.
REQ-009 PCTargetE  input  32  branch/jal target from Execute.
REQ-010 ALUResultE  input  32  jalr target from Execute.
REQ-011 InstrF  input  32  instruction word returned combinationally by instruction memory for address PCF.
REQ-012 PCF  output  32  current fetch address, drives instruction memory.
REQ-013 InstrD  output  32  registered instruction to Decode.
REQ-014 PCD  output  32  registered PC of InstrD.
REQ-015 PCPlus4D  output  32  registered PCD+4.
REQ-016 ValidD  output  1  1 = InstrD is a real fetched instruction; 0 = bubble.
REQ-017 FetchCount  output  32  count of cycles in which IF/ID captured a new instruction.
REQ-018 FlushCount  output  32  count of cycles with FlushD=1 (not in reset).

Function
REQ-019 PCPlus4F = PCF + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-020 PCNext: 00 -> PCPlus4F; 01 -> PCTargetE; 10 -> {ALUResultE[31:1],1'b0}; 11 -> same as 01.
REQ-021 PCF register: if PCSrcE != 00, load PCNext regardless of StallF; else if StallF=1, hold; else load PCPlus4F.
REQ-022 Redirect takes effect next cycle: PCF equals target one clock after PCSrcE != 00 is sampled.
REQ-023 IF/ID register priority: FlushD first, then StallD, then capture.
REQ-024 FlushD=1: InstrD <= NOP_INSTR, PCD <= 0, PCPlus4D <= 0, ValidD <= 0, even if StallD=1.
REQ-025 StallD=1, FlushD=0: InstrD, PCD, PCPlus4D, ValidD hold.
REQ-026 Capture (FlushD=0, StallD=0): InstrD <= InstrF, PCD <= PCF, PCPlus4D <= PCPlus4F, ValidD <= 1.
REQ-027 FetchCount increments by 1 on every capture cycle; wraps 32'hFFFF_FFFF -> 0.
REQ-028 FlushCount increments by 1 on every cycle with FlushD=1; wraps 32'hFFFF_FFFF -> 0.
REQ-029 StallF=1 with StallD=0 and FlushD=0 is legal: IF/ID captures the same InstrF/PCF again.
REQ-030 No combinational path from any input to PCD, InstrD, PCPlus4D, ValidD, or the counters; PCF is a pure register output.
REQ-031 Misaligned targets (bit1 set) are passed through unmodified; alignment faults are out of scope.

Reset
REQ-032 On rst=1 at a rising edge: PCF <= RESET_PC, InstrD <= NOP_INSTR, PCD <= 0, PCPlus4D <= 0, ValidD <= 0, FetchCount <= 0, FlushCount <= 0.
REQ-033 rst overrides StallF, StallD, FlushD, and PCSrcE in the same cycle; the first capture happens on the first edge with rst=0.
REQ-034 Reset asserted mid-stall or mid-redirect discards the pending state; no stale target is applied after reset.

Verification
REQ-035 Reset, then 4 free-running cycles with InstrF = PCF-derived pattern -> PCF = 0,4,8,C,10; ValidD=1 from cycle 2; FetchCount=4.
REQ-036 At PCF=0x10, hold StallF=StallD=1 for 3 cycles -> PCF stays 0x10, InstrD/PCD frozen, FetchCount unchanged; resumes at 0x14 after release.
REQ-037 PCSrcE=01, PCTargetE=0x200, FlushD=1 for one cycle -> next cycle PCF=0x200, InstrD=0x00000013, ValidD=0, FlushCount+1.
REQ-038 PCSrcE=10, ALUResultE=0x301 -> PCF=0x300 next cycle.
REQ-039 FlushD=1 and StallD=1 together, plus StallF=1 with PCSrcE=01 -> IF/ID flushed, PCF takes PCTargetE (redirect and flush win).
REQ-040 PCF=0xFFFF_FFFC with no stall -> next PCF=0x0000_0000; rst=1 pulsed during a StallF window -> PCF=RESET_PC, counters=0.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of a five-stage RV32 pipeline. It holds the fetch
//   PC, selects the next PC (sequential, branch/jal target or jalr target), and
//   drives the IF/ID pipeline register with stall, flush and bubble tracking.
//   Two free-running counters report capture and flush activity.
//
// Ports
//   clk         in   1   clock, all state updates on the rising edge
//   rst         in   1   synchronous active-high reset
//   StallF      in   1   hold PCF (a redirect still wins)
//   StallD      in   1   hold the IF/ID register
//   FlushD      in   1   turn the IF/ID register into a bubble (beats StallD)
//   PCSrcE      in   2   00 seq, 01 branch/jal, 10 jalr, 11 treated as 01
//   PCTargetE   in  32   branch/jal target
//   ALUResultE  in  32   jalr target (bit 0 cleared here)
//   InstrF      in  32   instruction memory read data for address PCF
//   PCF         out 32   current fetch address (register output)
//   InstrD      out 32   registered instruction for Decode
//   PCD         out 32   registered PC of InstrD
//   PCPlus4D    out 32   registered PCD + 4
//   ValidD      out  1   1 = InstrD is a real instruction, 0 = bubble
//   FetchCount  out 32   number of IF/ID capture cycles (wraps)
//   FlushCount  out 32   number of non-reset cycles with FlushD=1 (wraps)
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic [1:0]  PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [31:0] FetchCount,
  output logic [31:0] FlushCount
);

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JALR   = 2'b10,
    PC_RSVD   = 2'b11
  } pc_src_e;

  // State
  logic [31:0] pc_q,        pc_d;
  logic [31:0] instr_q,     instr_d;
  logic [31:0] pcd_q,       pcd_d;
  logic [31:0] pc_plus4_q,  pc_plus4_d;
  logic        valid_q,     valid_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Combinational helpers
  logic [31:0] pc_plus4_f;
  logic [31:0] pc_next;
  logic        redirect;
  logic        capture;
  pc_src_e     pc_src;

  assign pc_src     = pc_src_e'(PCSrcE);
  assign pc_plus4_f = pc_q + 32'd4;  // natural 32-bit wrap at 0xFFFF_FFFC
  assign redirect   = (pc_src != PC_SEQ);
  assign capture    = !FlushD && !StallD;

  // ---------------------------------------------------------------------------
  // Next-PC selection
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb gets a default first so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    pc_next = pc_plus4_f;
    unique case (pc_src)
      PC_SEQ:    pc_next = pc_plus4_f;
      PC_BRANCH: pc_next = PCTargetE;
      PC_JALR:   pc_next = ALUResultE & ~32'h1;
      PC_RSVD:   pc_next = PCTargetE;
    endcase
  end

  // A taken redirect from Execute must not be lost to a fetch stall, so it
  // overrides StallF; only the sequential case honours the stall.
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = pc_next;
    end else if (!StallF) begin
      pc_d = pc_plus4_f;
    end
  end

  // ---------------------------------------------------------------------------
  // IF/ID register next state: flush, then stall, then capture
  // ---------------------------------------------------------------------------
  always_comb begin
    instr_d    = instr_q;
    pcd_d      = pcd_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (FlushD) begin
      instr_d    = NOP_INSTR;
      pcd_d      = 32'd0;
      pc_plus4_d = 32'd0;
      valid_d    = 1'b0;
    end else if (!StallD) begin
      instr_d    = InstrF;
      pcd_d      = pc_q;
      pc_plus4_d = pc_plus4_f;
      valid_d    = 1'b1;
    end
  end

  // Activity counters; both wrap naturally at 2^32.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (capture) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (FlushD)  flush_cnt_d = flush_cnt_q + 32'd1;
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order. Reset is
  // synchronous and wins over every other input, so a pending redirect or
  // stall seen alongside rst is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      instr_q     <= NOP_INSTR;
      pcd_q       <= 32'd0;
      pc_plus4_q  <= 32'd0;
      valid_q     <= 1'b0;
      fetch_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pcd_q       <= pcd_d;
      pc_plus4_q  <= pc_plus4_d;
      valid_q     <= valid_d;
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // All outputs come straight from registers.
  assign PCF        = pc_q;
  assign InstrD     = instr_q;
  assign PCD        = pcd_q;
  assign PCPlus4D   = pc_plus4_q;
  assign ValidD     = valid_q;
  assign FetchCount = fetch_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Scoreboard bench for fetch_stage. The driver applies one cycle of inputs
//   at each falling edge, asks a behavioural model what the stage must look
//   like after the next rising edge, and queues that expectation. A separate
//   monitor pops one expectation shortly after every rising edge and compares
//   it with the DUT outputs. Directed scenarios come first, then random ones.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, StallD, FlushD;
  logic [1:0]  PCSrcE;
  logic [31:0] PCTargetE, ALUResultE, InstrF;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D, FetchCount, FlushCount;
  logic        ValidD;

  always #5 clk = ~clk;

  // Instruction memory stand-in: a pattern derived from the address.
  function automatic logic [31:0] imem(input logic [31:0] addr);
    return {addr[29:0], 2'b11} ^ 32'hA5A5_0000;
  endfunction

  assign InstrF = imem(PCF);

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk       (clk),
    .rst       (rst),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .ALUResultE(ALUResultE),
    .InstrF    (InstrF),
    .PCF       (PCF),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD),
    .FetchCount(FetchCount),
    .FlushCount(FlushCount)
  );

  // Architectural view of the stage after a clock edge.
  typedef struct {
    logic [31:0] pcf;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] fetches;
    logic [31:0] flushes;
  } view_t;

  view_t model = '{pcf: 32'd0, instr: 32'd0, pcd: 32'd0, pc4: 32'd0,
                   valid: 1'b0, fetches: 32'd0, flushes: 32'd0};
  view_t expq[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus and queue the state the stage must reach.
  task automatic drive(input logic r, input logic sf, input logic sd, input logic fd,
                       input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] alu);
    view_t nx;
    @(negedge clk);
    rst = r; StallF = sf; StallD = sd; FlushD = fd;
    PCSrcE = src; PCTargetE = tgt; ALUResultE = alu;
    nx = model;
    if (r) begin
      nx = '{pcf: RESET_PC, instr: NOP_INSTR, pcd: 32'd0, pc4: 32'd0,
             valid: 1'b0, fetches: 32'd0, flushes: 32'd0};
    end else begin
      // Fetch address: redirects always win, otherwise step by 4 unless stalled.
      if (src == 2'b10)      nx.pcf = {alu[31:1], 1'b0};
      else if (src != 2'b00) nx.pcf = tgt;
      else if (!sf)          nx.pcf = model.pcf + 32'd4;
      // Decode register sees the instruction at the address fetched this cycle.
      if (fd) begin
        nx.instr = NOP_INSTR; nx.pcd = 32'd0; nx.pc4 = 32'd0; nx.valid = 1'b0;
        nx.flushes = model.flushes + 32'd1;
      end else if (!sd) begin
        nx.instr = imem(model.pcf); nx.pcd = model.pcf;
        nx.pc4 = model.pcf + 32'd4; nx.valid = 1'b1;
        nx.fetches = model.fetches + 32'd1;
      end
    end
    model = nx;
    expq.push_back(nx);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
  endtask

  // Monitor: one expectation per rising edge once the driver has started.
  initial begin
    view_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("PCF",        PCF,        e.pcf);
        check("InstrD",     InstrD,     e.instr);
        check("PCD",        PCD,        e.pcd);
        check("PCPlus4D",   PCPlus4D,   e.pc4);
        check("ValidD",     {31'd0, ValidD}, {31'd0, e.valid});
        check("FetchCount", FetchCount, e.fetches);
        check("FlushCount", FlushCount, e.flushes);
      end
    end
  end

  initial begin
    int wait_cycles;
    rst = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    PCSrcE = 2'b00; PCTargetE = 32'd0; ALUResultE = 32'd0;

    // Reset, including one cycle where every other control is asserted.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 32'h0000_0444, 32'd0);
    // Free run: PCF 4,8,C,10 and four captures.
    idle(4);
    // Stall both stages at PCF=0x10, then resume toward 0x14.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 32'd0, 32'd0);
    idle(2);
    // Branch redirect to 0x200 with a flush of Decode.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 32'h0000_0200, 32'd0);
    idle(1);
    // jalr with odd target: bit 0 dropped.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 32'd0, 32'h0000_0301);
    idle(1);
    // Flush+StallD together, StallF with redirect: redirect and flush win.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 32'h0000_0480, 32'd0);
    idle(1);
    // Reserved select behaves like branch; misaligned target passes through.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 32'h0000_0102, 32'd0);
    // Wrap of the fetch address past the top of memory.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 32'hFFFF_FFFC, 32'd0);
    idle(2);
    // StallF alone: Decode captures the same instruction again.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    // Reset pulsed inside a stall window with a redirect pending.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 32'd0, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 32'h0000_0999, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [1:0] src;
      src = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      drive($urandom_range(0, 39) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0,
            src, $urandom, $urandom);
    end

    // Drain the scoreboard with a bounded wait.
    wait_cycles = 0;
    while (expq.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", expq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
